// File: rtl/noisy_wave_source_if.sv
// rtl/noisy_wave_source_if.sv - sample stream handshake between wave source and filter
interface noisy_wave_source_if;
    logic [31:0] noisy_data;
    logic        sample_valid;
    logic [15:0] sample_index;
    logic        sample_ready;

    modport master (
        output noisy_data,
        output sample_valid,
        output sample_index,
        input  sample_ready
    );

    modport slave (
        input  noisy_data,
        input  sample_valid,
        input  sample_index,
        output sample_ready
    );
endinterface

// File: rtl/noisy_wave_source.sv
// rtl/noisy_wave_source.sv - triangle wave plus LFSR noise sample generator with paced handshake
module noisy_wave_source #(
    parameter logic [31:0] STEP        = 32'd1000,
    parameter int          HALF_PERIOD = 16,
    parameter int          NUM_SAMPLES = 125,
    parameter int          SAMPLE_DIV  = 4,
    parameter int          NOISE_BITS  = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       noise_en,
    noisy_wave_source_if.master        bus,
    output logic                       busy,
    output logic                       done
);

    localparam int             PERIOD     = 2 * HALF_PERIOD;
    localparam int             PW         = $clog2(PERIOD);
    localparam int             CW         = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0]  GAP_LOAD   = CW'((SAMPLE_DIV > 1) ? SAMPLE_DIV - 2 : 0);
    localparam logic [PW-1:0]  PHASE_LAST = PW'(PERIOD - 1);
    localparam logic [15:0]    LAST_INDEX = 16'(NUM_SAMPLES - 1);
    localparam logic [15:0]    NOISE_MASK = 16'((32'd1 << NOISE_BITS) - 32'd1);

    typedef enum logic [1:0] {IDLE, PRESENT, GAP, FINISH} state_t;

    state_t         state;
    state_t         state_next;
    logic [15:0]    lfsr;
    logic [PW-1:0]  phase;
    logic [CW-1:0]  gap_cnt;
    logic [31:0]    data_r;
    logic [15:0]    index_r;
    logic [15:0]    lfsr_step;
    logic [PW-1:0]  phase_step;
    logic           transfer;
    logic           last_sample;

    // Triangle value for a phase plus optional low LFSR bits; arithmetic wraps mod 2^32.
    function automatic logic [31:0] form_sample(input logic [PW-1:0] ph,
                                                input logic [15:0] l,
                                                input logic ne);
        logic [31:0] tri_v;
        logic [31:0] noise;
        if (32'(ph) < 32'(HALF_PERIOD))
            tri_v = 32'(ph) * STEP;
        else
            tri_v = (32'(PERIOD) - 32'(ph)) * STEP;
        noise = ne ? 32'(l & NOISE_MASK) : 32'd0;
        return tri_v + noise;
    endfunction

    assign lfsr_step   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign phase_step  = (phase == PHASE_LAST) ? '0 : phase + PW'(1);
    assign transfer    = (state == PRESENT) && bus.sample_ready;
    assign last_sample = (index_r == LAST_INDEX);

    assign bus.noisy_data   = data_r;
    assign bus.sample_index = index_r;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_next       = state;
        bus.sample_valid = 1'b0;
        busy             = (state != IDLE);
        done             = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_next = PRESENT;
            end
            PRESENT: begin
                bus.sample_valid = 1'b1;
                if (bus.sample_ready) begin
                    if (last_sample)
                        state_next = FINISH;
                    else if (SAMPLE_DIV == 1)
                        state_next = PRESENT;
                    else
                        state_next = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == '0)
                    state_next = PRESENT;
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Sample datapath: LFSR, phase, index and the held sample advance only on start or transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr    <= LFSR_SEED;
            phase   <= '0;
            gap_cnt <= '0;
            data_r  <= '0;
            index_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lfsr    <= LFSR_SEED;
                        phase   <= '0;
                        index_r <= '0;
                        data_r  <= form_sample('0, LFSR_SEED, noise_en);
                    end
                end
                PRESENT: begin
                    if (transfer && !last_sample) begin
                        lfsr    <= lfsr_step;
                        phase   <= phase_step;
                        index_r <= index_r + 16'd1;
                        data_r  <= form_sample(phase_step, lfsr_step, noise_en);
                        gap_cnt <= GAP_LOAD;
                    end
                end
                GAP: begin
                    if (gap_cnt != '0)
                        gap_cnt <= gap_cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_noisy_wave_source.sv
// tb/tb_noisy_wave_source.sv - self-checking bench for noisy_wave_source
module tb_noisy_wave_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start0, start1, start2;
    logic ne0, ne1, ne2;
    wire  busy0, busy1, busy2;
    wire  done0, done1, done2;

    noisy_wave_source_if bus0 ();
    noisy_wave_source_if bus1 ();
    noisy_wave_source_if bus2 ();

    noisy_wave_source #(.SAMPLE_DIV(4)) dut0 (
        .clk(clk), .reset(rst_n), .start(start0), .noise_en(ne0),
        .bus(bus0), .busy(busy0), .done(done0));

    noisy_wave_source #(.SAMPLE_DIV(1)) dut1 (
        .clk(clk), .reset(rst_n), .start(start1), .noise_en(ne1),
        .bus(bus1), .busy(busy1), .done(done1));

    noisy_wave_source #(.STEP(32'h8000_0000), .HALF_PERIOD(4), .NUM_SAMPLES(10), .SAMPLE_DIV(2)) dut2 (
        .clk(clk), .reset(rst_n), .start(start2), .noise_en(ne2),
        .bus(bus2), .busy(busy2), .done(done2));

    int checks = 0;
    int errors = 0;
    int sel = 0;

    logic        o_valid, o_busy, o_done;
    logic [31:0] o_data;
    logic [15:0] o_idx;

    logic [31:0] d_q[$];
    logic [15:0] i_q[$];
    bit          ne_q[$];
    int          done_cnt;

    always_comb begin
        case (sel)
            1: begin
                o_valid = bus1.sample_valid; o_data = bus1.noisy_data; o_idx = bus1.sample_index;
                o_busy = busy1; o_done = done1;
            end
            2: begin
                o_valid = bus2.sample_valid; o_data = bus2.noisy_data; o_idx = bus2.sample_index;
                o_busy = busy2; o_done = done2;
            end
            default: begin
                o_valid = bus0.sample_valid; o_data = bus0.noisy_data; o_idx = bus0.sample_index;
                o_busy = busy0; o_done = done0;
            end
        endcase
    end

    // Reference: sample k of a burst from the wave rules, LFSR seeded and stepped k times.
    function automatic logic [31:0] model(input int s, input int k, input bit ne);
        logic [31:0] step;
        logic [31:0] tri_v;
        logic [15:0] l;
        int          half;
        int          ph;
        step = (s == 2) ? 32'h8000_0000 : 32'd1000;
        half = (s == 2) ? 4 : 16;
        ph   = k % (2 * half);
        if (ph < half) tri_v = step * 32'(ph);
        else           tri_v = step * 32'(2 * half - ph);
        l = 16'hACE1;
        repeat (k) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        return tri_v + (ne ? {24'd0, l[7:0]} : 32'd0);
    endfunction

    function automatic bit ne_of(input int k);
        return (k < ne_q.size()) ? ne_q[k] : 1'b0;
    endfunction

    task automatic clear_log();
        d_q.delete(); i_q.delete(); ne_q.delete(); done_cnt = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        if (o_done) done_cnt++;
    endtask

    task automatic drive(input bit rdy, input bit st, input bit ne);
        if (st && !o_busy) ne_q.push_back(ne);
        if (o_valid && rdy) begin
            d_q.push_back(o_data); i_q.push_back(o_idx); ne_q.push_back(ne);
        end
        case (sel)
            1:       begin bus1.sample_ready = rdy; start1 = st; ne1 = ne; end
            2:       begin bus2.sample_ready = rdy; start2 = st; ne2 = ne; end
            default: begin bus0.sample_ready = rdy; start0 = st; ne0 = ne; end
        endcase
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b want 0", s, o_valid); end
            checks++; if (o_data !== 32'd0) begin errors++; $display("FAIL reset_data[%0d]: got %0d want 0", s, o_data); end
            checks++; if (o_idx !== 16'd0) begin errors++; $display("FAIL reset_index[%0d]: got %0d want 0", s, o_idx); end
            checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", s, o_busy); end
            checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %b want 0", s, o_done); end
        end
    endtask

    task automatic test_back_to_back();
        sel = 1; clear_log();
        tick(); drive(1, 1, 0);
        for (int n = 0; n < 125; n++) begin
            tick();
            checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", n, o_valid); end
            checks++; if (o_idx !== 16'(n)) begin errors++; $display("FAIL b2b_index[%0d]: got %0d want %0d", n, o_idx, n); end
            checks++; if (o_data !== model(1, n, 0)) begin errors++; $display("FAIL b2b_data[%0d]: got %0d want %0d", n, o_data, model(1, n, 0)); end
            drive(1, 0, 0);
        end
        tick();
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", o_done); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_finish: got %b want 1", o_busy); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_finish: got %b want 0", o_valid); end
        drive(1, 0, 0);
        tick();
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_idle: got %b want 0", o_busy); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL b2b_done_count: got %0d want 1", done_cnt); end
        checks++; if (d_q.size() !== 125) begin errors++; $display("FAIL b2b_count: got %0d want 125", d_q.size()); end
        if (d_q.size() == 125) begin
            checks++; if (d_q[16] !== 32'd16000) begin errors++; $display("FAIL b2b_peak: got %0d want 16000", d_q[16]); end
            checks++; if (d_q[31] !== 32'd1000) begin errors++; $display("FAIL b2b_idx31: got %0d want 1000", d_q[31]); end
            checks++; if (d_q[32] !== 32'd0) begin errors++; $display("FAIL b2b_idx32: got %0d want 0", d_q[32]); end
        end
        drive(0, 0, 0);
    endtask

    task automatic test_noise_gap();
        int  low_run;
        bool_loop: begin end
        sel = 0; clear_log();
        low_run = -1;
        tick(); drive(1, 1, 1);
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (o_done) break;
            if (o_valid) begin
                if (low_run >= 0) begin
                    checks++; if (low_run !== 3) begin errors++; $display("FAIL gap_len[%0d]: got %0d want 3", o_idx, low_run); end
                end
                low_run = 0;
            end else if (low_run >= 0) begin
                low_run++;
            end
            drive(1, 0, 1);
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL gap_done_count: got %0d want 1", done_cnt); end
        checks++; if (d_q.size() !== 125) begin errors++; $display("FAIL gap_count: got %0d want 125", d_q.size()); end
        if (d_q.size() == 125) begin
            checks++; if (d_q[0] !== 32'd225) begin errors++; $display("FAIL gap_idx0: got %0d want 225", d_q[0]); end
            checks++; if (d_q[1] !== 32'd1195) begin errors++; $display("FAIL gap_idx1: got %0d want 1195", d_q[1]); end
        end
        tick(); drive(0, 0, 0);
    endtask

    task automatic test_backpressure_random();
        bit          finished;
        bit          stalled;
        bit          pulsed;
        bit          rdy;
        bit          st;
        logic [31:0] held;
        sel = 0; clear_log();
        finished = 0; stalled = 0; pulsed = 0;
        tick(); drive(1, 1, 1'($urandom_range(0, 1)));
        for (int c = 0; c < 5000 && !finished; c++) begin
            tick();
            if (o_done) begin
                finished = 1;
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
                st  = 0;
                if (o_valid && o_idx == 16'd5 && !stalled) begin
                    stalled = 1;
                    held = o_data;
                    for (int j = 0; j < 10; j++) begin
                        drive(0, 0, 1'($urandom_range(0, 1)));
                        tick();
                        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", j, o_valid); end
                        checks++; if (o_idx !== 16'd5) begin errors++; $display("FAIL stall_index[%0d]: got %0d want 5", j, o_idx); end
                        checks++; if (o_data !== held) begin errors++; $display("FAIL stall_data[%0d]: got %0d want %0d", j, o_data, held); end
                    end
                    rdy = 1;
                end
                if (o_valid && o_idx == 16'd40 && !pulsed) begin
                    st = 1; pulsed = 1;
                end
                drive(rdy, st, 1'($urandom_range(0, 1)));
            end
        end
        checks++; if (!finished) begin errors++; $display("FAIL bp_timeout: got no done want done"); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
        checks++; if (d_q.size() !== 125) begin errors++; $display("FAIL bp_count: got %0d want 125", d_q.size()); end
        for (int k = 0; k < d_q.size(); k++) begin
            checks++; if (i_q[k] !== 16'(k)) begin errors++; $display("FAIL bp_index[%0d]: got %0d want %0d", k, i_q[k], k); end
            checks++; if (d_q[k] !== model(0, k, ne_of(k))) begin errors++; $display("FAIL bp_data[%0d]: got %0d want %0d", k, d_q[k], model(0, k, ne_of(k))); end
        end
        drive(0, 0, 0);
        tick();
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL bp_busy_idle: got %b want 0", o_busy); end
    endtask

    task automatic test_wrap();
        sel = 2; clear_log();
        tick(); drive(1, 1, 0);
        for (int c = 0; c < 200; c++) begin
            tick();
            if (o_done) break;
            drive(1, 0, 0);
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt); end
        checks++; if (d_q.size() !== 10) begin errors++; $display("FAIL wrap_count: got %0d want 10", d_q.size()); end
        if (d_q.size() == 10) begin
            checks++; if (d_q[2] !== 32'd0) begin errors++; $display("FAIL wrap_idx2: got %h want 0", d_q[2]); end
            checks++; if (d_q[3] !== 32'h8000_0000) begin errors++; $display("FAIL wrap_idx3: got %h want 80000000", d_q[3]); end
            for (int k = 0; k < 10; k++) begin
                checks++; if (d_q[k] !== model(2, k, 0)) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", k, d_q[k], model(2, k, 0)); end
            end
        end
        drive(0, 0, 0);
    endtask

    task automatic test_reset_mid();
        bit reached;
        sel = 0; clear_log();
        reached = 0;
        tick(); drive(1, 1, 1);
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (i_q.size() == 61 && !o_valid) begin
                reached = 1;
                break;
            end
            drive(1, 0, 1);
        end
        checks++; if (!reached) begin errors++; $display("FAIL mid_reach: got no gap after idx60 want gap"); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", o_valid); end
        checks++; if (o_data !== 32'd0) begin errors++; $display("FAIL mid_data: got %0d want 0", o_data); end
        checks++; if (o_idx !== 16'd0) begin errors++; $display("FAIL mid_index: got %0d want 0", o_idx); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", o_busy); end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL mid_no_done: got %0d want 0", done_cnt); end
        clear_log();
        drive(1, 1, 1);
        tick();
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL mid_restart_valid: got %b want 1", o_valid); end
        checks++; if (o_idx !== 16'd0) begin errors++; $display("FAIL mid_restart_index: got %0d want 0", o_idx); end
        checks++; if (o_data !== 32'd225) begin errors++; $display("FAIL mid_restart_data: got %0d want 225", o_data); end
        drive(0, 0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        start0 = 0; start1 = 0; start2 = 0;
        ne0 = 0; ne1 = 0; ne2 = 0;
        bus0.sample_ready = 0; bus1.sample_ready = 0; bus2.sample_ready = 0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        sel = 0;
        test_back_to_back();
        test_noise_gap();
        test_backpressure_random();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/noisy_wave_source.md
Name: noisy_wave_source

Overview:
- Stimulus/source block on the transmit side of the filter's sample interface. It generates a stream of 32-bit "noisy" samples: a deterministic triangle wave plus LFSR noise.
- Samples are delivered over a valid/ready handshake at a programmable rate, so the low-pass filter path can be driven in hardware without a preloaded memory file.
- It sits between the control FSM (start/noise select) and the filter's noisy_data input.

Parameters:
- STEP, 1000, triangle increment per sample (unsigned 32-bit)
- HALF_PERIOD, 16, samples per rising half of the triangle (period = 2*HALF_PERIOD); must be >= 1
- NUM_SAMPLES, 125, samples emitted per burst; must be >= 1
- SAMPLE_DIV, 4, minimum clock cycles from one handshake transfer to the next sample_valid; must be >= 1
- NOISE_BITS, 8, number of LFSR low bits added as noise (1..16)
- LFSR_SEED, 16'hACE1, LFSR value loaded on every accepted start; must be nonzero

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a burst; honoured only in IDLE
- noise_en  input  1  1 = add noise, 0 = pure triangle; sampled when each sample is formed
- sample_ready  input  1  downstream can accept a sample
- noisy_data  output  32  current sample; stable while sample_valid=1 and not yet accepted
- sample_valid  output  1  noisy_data holds a sample
- sample_index  output  16  index of the sample on noisy_data (0..NUM_SAMPLES-1)
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the last sample is accepted

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, noisy_data=0, sample_valid=0, sample_index=0, busy=0, done=0, LFSR=LFSR_SEED, phase=0, rate counter=0.
- FSM states: IDLE, PRESENT, GAP, FINISH.
- IDLE, start=1:
  - Load LFSR=LFSR_SEED, phase=0, index=0.
  - Form sample 0 and go to PRESENT. sample_valid=1 on the next cycle (1-cycle latency from start).
- PRESENT:
  - sample_valid=1. noisy_data and sample_index are held until sample_valid && sample_ready at a rising edge (transfer).
  - On transfer, if index==NUM_SAMPLES-1, go to FINISH.
  - On transfer otherwise, advance the LFSR once, phase=(phase+1) mod 2*HALF_PERIOD, index+1, and form the next sample.
    - SAMPLE_DIV==1: stay in PRESENT with valid held high; back-to-back, one sample per cycle while ready=1.
    - SAMPLE_DIV>1: go to GAP with valid=0 for SAMPLE_DIV-1 cycles, then return to PRESENT.
- GAP: sample_valid=0. The counter counts down; sample_ready is ignored.
- FINISH: done=1 for exactly one cycle, sample_valid=0, busy=1. Go to IDLE on the next cycle. sample_index keeps its last value until the next start.
- start is ignored outside IDLE, including when it coincides with a transfer.
- Sample formation:
  - tri = phase*STEP when phase<HALF_PERIOD, else (2*HALF_PERIOD-phase)*STEP.
  - noise = zero-extended LFSR[NOISE_BITS-1:0] when noise_en, else 0.
  - noisy_data = (tri + noise) mod 2^32. No saturation; overflow wraps.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. fb = L[15]^L[13]^L[12]^L[10]; next = {L[14:0], fb}. It advances only on a transfer, never during stalls or GAP.
- Backpressure: with sample_ready=0 in PRESENT, all outputs are frozen indefinitely.
- Reset mid-burst: return immediately to the reset values. No done pulse. The next start restarts from sample 0 with the seed.

Test Plan:
- Reset then start, noise_en=0, SAMPLE_DIV=1, ready=1 -> valid rises 1 cycle after start. noisy_data = 0,1000,...,16000 (idx16),15000,...,1000 (idx31),0 (idx32). One sample per cycle; done pulses once after idx124; busy falls the following cycle.
- noise_en=1, defaults -> idx0 = 225 (0x00E1). idx1 = 1000+0xC3 = 1195 (LFSR 0x59C3). Valid low for 3 cycles between transfers.
- Hold ready=0 for 10 cycles at idx5 -> noisy_data/sample_index stable, LFSR not advanced. After release, idx5 is transferred once with no skipped or duplicated index.
- Pulse start at idx40 while busy -> ignored: burst still ends at idx124 with exactly 125 transfers and one done pulse.
- Assert reset=0 asynchronously at idx60 (mid-GAP) -> outputs go to 0 at once, no done. A later start gives idx0 = 225 again (noise_en=1).
- STEP=32'h8000_0000, HALF_PERIOD=4, noise_en=0 -> idx2 = 0 (wrap) and idx3 = 32'h8000_0000, confirming mod-2^32 arithmetic.
